mem_port_arbiter: RTL and testbench

- Shares one single-ported, synchronous-read unified memory between the CPU's instruction-fetch port (IF) and its load/store port (DM).
- Arbitrates between the two ports and sequences each access.
- Steers byte lanes for sb/sh/sw and sign/zero-extends lb/lh/lbu/lhu results.
- Reports ready back to the CPU, which stalls its PC update and write-back until ready.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, access-size
// codes and the port-owner encoding used to steer the memory address mux.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        ERR_DM  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the CPU data port and the 32-bit memory word:
// store replication / byte enables / misalignment check, and load extraction.
module mem_lane_align
    import arb_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    output logic        misaligned,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store side: size code 11 falls into the word branch.
    always_comb begin
        st_be        = 4'b1111;
        st_wdata_rep = st_wdata;
        misaligned   = 1'b0;
        case (st_size)
            SZ_BYTE: begin
                st_be        = 4'b0001 << st_addr_lo;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_be        = 4'b0011 << {st_addr_lo[1], 1'b0};
                st_wdata_rep = {2{st_wdata[15:0]}};
                misaligned   = st_addr_lo[0];
            end
            default: begin
                st_be        = 4'b1111;
                st_wdata_rep = st_wdata;
                misaligned   = (st_addr_lo != 2'b00);
            end
        endcase
    end

    // Load side: pick the addressed lane, then sign- or zero-extend.
    always_comb begin
        byte_s = ld_word[{ld_addr_lo, 3'b000} +: 8];
        half_s = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & byte_s[7]}}, byte_s};
            SZ_HALF: ld_data = {{16{~ld_unsigned & half_s[15]}}, half_s};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between the IF and DM ports, DM first.
// Optional macro ARB_STARVE_GUARD_EN bounds consecutive DM grants while IF waits.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int MAX_DM_STREAK = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic              dm_unsigned,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ready,
    output logic              dm_misaligned,
    output logic              mem_en,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t      state_r;
    logic        dm_we_r;
    logic [1:0]  dm_size_r;
    logic        dm_unsigned_r;
    logic [1:0]  dm_addr_lo_r;

    logic        starve_s;
    logic        grant_dm_s;
    logic        grant_if_s;
    owner_t      owner_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_rep_s;
    logic        mis_s;
    logic [31:0] ld_data_s;
    logic        unused_s;

    assign unused_s = ^if_addr[1:0];

`ifdef ARB_STARVE_GUARD_EN
    localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
    logic [STREAK_W-1:0] streak_r;

    assign starve_s = (streak_r >= STREAK_W'(MAX_DM_STREAK));

    // Counts DM grants taken while IF is waiting; any IF grant clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_r <= '0;
        end else if (grant_if_s) begin
            streak_r <= '0;
        end else if (grant_dm_s && if_req && !starve_s) begin
            streak_r <= streak_r + STREAK_W'(1);
        end else begin
            streak_r <= streak_r;
        end
    end
`else
    assign starve_s = 1'b0;
`endif

    assign grant_dm_s = (state_r == IDLE) && dm_req && !(starve_s && if_req);
    assign grant_if_s = (state_r == IDLE) && if_req && !grant_dm_s;
    assign owner_s    = grant_dm_s ? OWN_DM : OWN_IF;

    mem_lane_align u_align (
        .st_size      (dm_size),
        .st_addr_lo   (dm_addr[1:0]),
        .st_wdata     (dm_wdata),
        .st_be        (be_s),
        .st_wdata_rep (wdata_rep_s),
        .misaligned   (mis_s),
        .ld_size      (dm_size_r),
        .ld_unsigned  (dm_unsigned_r),
        .ld_addr_lo   (dm_addr_lo_r),
        .ld_word      (mem_rdata),
        .ld_data      (ld_data_s)
    );

    // Memory strobe is issued in the grant cycle itself; misaligned DM never reaches memory.
    assign mem_en    = grant_if_s || (grant_dm_s && !mis_s);
    assign mem_addr  = (owner_s == OWN_DM) ? dm_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
    assign mem_be    = (grant_dm_s && dm_we && !mis_s) ? be_s : 4'b0000;
    assign mem_wdata = wdata_rep_s;

    // Arbitration FSM; load-shaping fields are captured so the ready cycle ignores input changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            dm_we_r       <= 1'b0;
            dm_size_r     <= SZ_WORD;
            dm_unsigned_r <= 1'b0;
            dm_addr_lo_r  <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_dm_s) begin
                        dm_we_r       <= dm_we;
                        dm_size_r     <= dm_size;
                        dm_unsigned_r <= dm_unsigned;
                        dm_addr_lo_r  <= dm_addr[1:0];
                        state_r       <= mis_s ? ERR_DM : BUSY_DM;
                    end else if (grant_if_s) begin
                        state_r <= BUSY_IF;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Completion outputs are decoded from the registered state.
    always_comb begin
        if_ready      = 1'b0;
        if_rdata      = 32'h0000_0000;
        dm_ready      = 1'b0;
        dm_rdata      = 32'h0000_0000;
        dm_misaligned = 1'b0;
        case (state_r)
            BUSY_IF: begin
                if_ready = 1'b1;
                if_rdata = mem_rdata;
            end
            BUSY_DM: begin
                dm_ready = 1'b1;
                dm_rdata = dm_we_r ? 32'h0000_0000 : ld_data_s;
            end
            ERR_DM: begin
                dm_ready      = 1'b1;
                dm_misaligned = 1'b1;
            end
            default: if_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized
// traffic against a byte-level memory model. Starvation check needs ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [31:0] d;
        logic        m;
    } dexp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, dm_unsigned;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [1:0]  dm_size;
    logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, dm_misaligned, mem_en;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;

    logic [31:0] tmem [0:127];
    logic [31:0] img  [0:127];
    logic [31:0] rmem [0:127];
    logic        mem_load;

    logic [31:0] if_q[$];
    dexp_t       dm_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_unsigned(dm_unsigned),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .dm_misaligned(dm_misaligned), .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous-read memory seen by the DUT
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 128; i++) tmem[i] <= img[i];
        end else if (mem_en) begin
            mem_rdata <= tmem[mem_addr[6:0]];
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) tmem[mem_addr[6:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic is_mis(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd0) return 1'b0;
        if (size == 2'd1) return (addr % 2) != 0;
        return (addr % 4) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
        logic [31:0] w, v;
        w = rmem[addr[8:2]];
        if (size == 2'd0) begin
            v = (w >> (8 * (addr % 4))) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (w >> (16 * ((addr / 2) % 2))) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] w;
        int          lo;
        w  = rmem[addr[8:2]];
        lo = int'(addr % 4);
        if (size == 2'd0)      w[8*lo +: 8]         = wd[7:0];
        else if (size == 2'd1) w[16*(lo/2) +: 16]   = wd[15:0];
        else                   w                    = wd;
        rmem[addr[8:2]] = w;
    endtask

    // Monitor: pops expected responses whenever a ready pulse appears
    always @(negedge clk) begin
        if (!rst && (if_ready || dm_ready)) begin
            chk("ready_overlap", {31'd0, if_ready & dm_ready}, 32'd0);
            chk("mem_en_while_busy", {31'd0, mem_en}, 32'd0);
            if (if_ready) begin
                if (if_q.size() == 0) chk("if_unexpected_ready", 32'd1, {31'd0, rst});
                else chk("if_rdata", if_rdata, if_q.pop_front());
            end
            if (dm_ready) begin
                if (dm_q.size() == 0) begin
                    chk("dm_unexpected_ready", 32'd1, {31'd0, rst});
                end else begin
                    dexp_t e;
                    e = dm_q.pop_front();
                    chk("dm_rdata", dm_rdata, e.d);
                    chk("dm_misaligned", {31'd0, dm_misaligned}, {31'd0, e.m});
                end
            end
        end
    end

    task automatic do_if(input logic [31:0] addr, output int lat, output logic en0,
                         output logic [29:0] a0, output logic [31:0] rd);
        bit done;
        if_q.push_back(rmem[addr[8:2]]);
        if_addr = addr;
        if_req  = 1'b1;
        lat = 0; en0 = 1'b0; a0 = '0; rd = '0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (lat == 0) begin en0 = mem_en; a0 = mem_addr; end
            if (if_ready) begin
                rd = if_rdata; done = 1'b1;
            end else if (lat >= 30) begin
                chk("if_timeout", lat, 32'd0); done = 1'b1;
            end else begin
                lat++;
            end
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_dm(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, output int lat,
                         output logic en0, output logic [3:0] be0, output logic [31:0] wd0,
                         output logic [31:0] rd);
        bit    done;
        dexp_t e;
        if (is_mis(size, addr)) begin
            e.d = 32'd0; e.m = 1'b1;
        end else if (we) begin
            e.d = 32'd0; e.m = 1'b0;
            ref_store(size, addr, wd);
        end else begin
            e.d = ref_load(size, uns, addr); e.m = 1'b0;
        end
        dm_q.push_back(e);
        dm_we = we; dm_size = size; dm_unsigned = uns; dm_addr = addr; dm_wdata = wd;
        dm_req = 1'b1;
        lat = 0; en0 = 1'b0; be0 = '0; wd0 = '0; rd = '0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (lat == 0) begin en0 = mem_en; be0 = mem_be; wd0 = mem_wdata; end
            if (dm_ready) begin
                rd = dm_rdata; done = 1'b1;
            end else if (lat >= 30) begin
                chk("dm_timeout", lat, 32'd0); done = 1'b1;
            end else begin
                lat++;
            end
        end
        @(posedge clk); #1;
        dm_req = 1'b0;
        dm_addr = $urandom; dm_wdata = $urandom;
    endtask

    initial begin
        int l, l2; logic e; logic [29:0] a; logic [3:0] b; logic [31:0] w, r; logic [31:0] old;
        rst = 1'b1; mem_load = 1'b1;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'd0;
        dm_unsigned = 1'b0; dm_addr = '0; dm_wdata = '0;
        for (int i = 0; i < 128; i++) begin img[i] = $urandom; rmem[i] = img[i]; end
        img[4] = 32'h0050_0093; rmem[4] = 32'h0050_0093;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {mem_en, mem_be, if_ready, dm_ready, dm_misaligned}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_load = 1'b0;
        @(posedge clk); #1;

        // 1: IF-only fetch
        do_if(32'h10, l, e, a, r);
        chk("t1_mem_en", {31'd0, e}, 32'd1);
        chk("t1_mem_addr", {2'd0, a}, 32'h4);
        chk("t1_latency", l, 32'd1);
        chk("t1_rdata", r, 32'h0050_0093);

        // 2: simultaneous IF and DM
        fork
            begin
                logic e2; logic [3:0] b2; logic [31:0] w2, r2;
                do_dm(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, l2, e2, b2, w2, r2);
            end
            begin
                logic e3; logic [29:0] a3; logic [31:0] r3;
                do_if(32'h14, l, e3, a3, r3);
            end
        join
        chk("t2_dm_latency", l2, 32'd1);
        chk("t2_if_latency", l, 32'd3);

        // 3: store byte then reload the word
        old = rmem[32'h100 >> 2];
        do_dm(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00AB, l, e, b, w, r);
        chk("t3_be", {28'd0, b}, 32'h8);
        chk("t3_wdata", w, 32'hABAB_ABAB);
        chk("t3_latency", l, 32'd1);
        do_dm(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, l, e, b, w, r);
        chk("t3_reload", r, (old & 32'h00FF_FFFF) | 32'hAB00_0000);

        // 4: load extraction and extension
        do_dm(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF_1234, l, e, b, w, r);
        chk("t4_sw_be", {28'd0, b}, 32'hF);
        do_dm(1'b0, 2'd0, 1'b0, 32'h102, 32'd0, l, e, b, w, r); chk("t4_lb", r, 32'hFFFF_FFFF);
        do_dm(1'b0, 2'd0, 1'b1, 32'h102, 32'd0, l, e, b, w, r); chk("t4_lbu", r, 32'h0000_00FF);
        do_dm(1'b0, 2'd1, 1'b0, 32'h102, 32'd0, l, e, b, w, r); chk("t4_lh", r, 32'hFFFF_80FF);
        do_dm(1'b0, 2'd1, 1'b1, 32'h100, 32'd0, l, e, b, w, r); chk("t4_lhu", r, 32'h0000_1234);

        // 5: misaligned word load
        do_dm(1'b0, 2'd2, 1'b0, 32'h102, 32'd0, l, e, b, w, r);
        chk("t5_mem_en", {31'd0, e}, 32'd0);
        chk("t5_latency", l, 32'd1);
        chk("t5_rdata", r, 32'd0);

        // 6: reset while BUSY_DM abandons the access
        dm_we = 1'b0; dm_size = 2'd2; dm_addr = 32'h104; dm_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; dm_req = 1'b0;
        @(negedge clk);
        chk("t6_ready_in_rst", {31'd0, dm_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_no_ready", {31'd0, dm_ready}, 32'd0);
        end
        @(posedge clk); #1;
        do_if(32'h18, l, e, a, r);
        chk("t6_idle_grant", {31'd0, e}, 32'd1);
        chk("t6_idle_latency", l, 32'd1);

`ifdef ARB_STARVE_GUARD_EN
        fork
            begin
                logic e2; logic [3:0] b2; logic [31:0] w2, r2; int l3;
                for (int k = 0; k < 6; k++)
                    do_dm(1'b0, 2'd2, 1'b0, 32'h140 + 32'(4*k), 32'd0, l3, e2, b2, w2, r2);
            end
            begin
                logic e3; logic [29:0] a3; logic [31:0] r3;
                do_if(32'h30, l, e3, a3, r3);
            end
        join
        chk("starve_if_after_4_dm", l, 32'd9);
`endif

        // Randomized concurrent traffic
        fork
            begin
                logic e2; logic [29:0] a2; logic [31:0] r2; int l4;
                for (int k = 0; k < 40; k++) begin
                    do_if(32'($urandom_range(0, 255)), l4, e2, a2, r2);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            begin
                logic e3; logic [3:0] b3; logic [31:0] w3, r3; int l5;
                for (int k = 0; k < 60; k++) begin
                    do_dm(1'($urandom), 2'($urandom), 1'($urandom),
                          32'h100 + 32'($urandom_range(0, 255)), $urandom, l5, e3, b3, w3, r3);
                    repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                end
            end
        join
        repeat (3) @(negedge clk);
        chk("if_queue_drained", if_q.size(), 32'd0);
        chk("dm_queue_drained", dm_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
